// File: rtl/wide_addsub_seq_if.sv
// Operand/result bundle for the byte-serial add/subtract sequencer.
// master drives the request side; slave is the sequencer itself.
interface wide_addsub_seq_if #(parameter int NBYTES = 4);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/wide_addsub_seq.sv
// Byte-serial W-bit add/sub on one 8-bit ripple slice; done NBYTES edges after accept, one op per NBYTES+2 cycles.
// No backpressure: start is sampled only in IDLE and dropped (not queued) while RUN/DONE.
module wide_addsub_seq #(
  parameter int NBYTES = 4
) (
  input logic             clk,
  input logic             rst_n,
  wide_addsub_seq_if.slave bus
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] res_q;
  logic                   carry_q;
  logic [IW-1:0]          idx;
  logic                   busy_q;
  logic                   done_q;
  logic                   cout_q;
  logic                   ovf_q;
  logic                   zero_q;

  logic [7:0]             sum;
  logic                   co;
  logic                   c7;

  // Full-adder chain; also exposes the carry into bit 7 for overflow.
  function automatic logic [9:0] slice8(input logic [7:0] x, input logic [7:0] y,
                                        input logic cin);
    logic [8:0] c;
    logic [7:0] s;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[7], c[8], s};
  endfunction

  assign {c7, co, sum} = slice8(a_q[idx], b_q[idx], carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is a + ~b + 1: invert b here, seed the carry with 1.
            a_q     <= bus.a;
            b_q     <= bus.mode ? bus.b : ~bus.b;
            carry_q <= ~bus.mode;
            idx     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q[idx] <= sum;
          carry_q    <= co;
          if (idx == IW'(NBYTES - 1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cout_q <= co;
            ovf_q  <= c7 ^ co;
            zero_q <= ({sum, res_q[NBYTES-2:0]} == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule
